uart_rx_engine_cfg: RTL

UART_RX_ENGINE_CFG -- requirements
Module: uart_rx_engine_cfg

---
 rtl/uart_rx_engine_cfg.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_engine_cfg.sv
// Configurable oversampling UART receiver with a one-deep output buffer and overrun reporting.
// Build option: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around the bit centre.
module uart_rx_engine_cfg #(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              baud_tick,
    input  logic              uart_rx,
    input  logic [3:0]        cfg_data_bits,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_stop2,
    output logic              rx_out_valid,
    input  logic              rx_out_ready,
    output logic [DATA_W-1:0] rx_out_data,
    output logic              rx_out_perr,
    output logic              rx_out_ferr,
    output logic              rx_overrun,
    output logic              rx_busy,
    output logic [2:0]        dbg_state
);

    // Handshake: a frame moves downstream on any cycle where rx_out_valid && rx_out_ready;
    // valid never drops without that transfer, and data/perr/ferr hold still while valid && !ready.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam int            CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] CNT_VOTE0  = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] CNT_VOTE1  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_DECIDE = CW'(OVERSAMPLE / 2 - 1);
`endif

    logic              r_sync1;
    logic              r_sync2;
    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_cnt;
    logic [3:0]        r_bit_idx;
    logic              r_stop_idx;
    logic [3:0]        r_bits;
    logic              r_par_en;
    logic              r_par_odd;
    logic              r_stop2;
    logic [DATA_W-1:0] r_shift;
    logic              r_perr;
    logic              r_ferr;
    logic              r_start_hi;
    logic              r_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_perr;
    logic              r_out_ferr;
    logic              r_overrun;

    logic              w_line;
    logic              w_sample_bit;
    logic              w_sample_pt;
    logic              w_bit_end;
    logic              w_last_data;
    logic              w_last_stop;
    logic              w_commit;
    logic              w_ferr_final;
    logic [3:0]        w_cfg_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end

    assign w_line = r_sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_vote;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vote <= 2'b11;
        end else if (baud_tick && (r_cnt == CNT_VOTE0)) begin
            r_vote[0] <= w_line;
        end else if (baud_tick && (r_cnt == CNT_VOTE1)) begin
            r_vote[1] <= w_line;
        end
    end

    assign w_sample_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_line) | (r_vote[1] & w_line);
`else
    assign w_sample_bit = w_line;
`endif

    assign w_sample_pt  = baud_tick && (r_cnt == CNT_DECIDE);
    assign w_bit_end    = baud_tick && (r_cnt == CNT_LAST);
    assign w_last_data  = (r_bit_idx == (r_bits - 4'd1));
    assign w_last_stop  = (r_stop_idx == r_stop2);
    assign w_commit     = (r_state == S_STOP) && w_sample_pt && w_last_stop;
    assign w_ferr_final = r_ferr | ~w_sample_bit;
    assign w_cfg_bits   = ((cfg_data_bits >= 4'd5) && (cfg_data_bits <= 4'(DATA_W)))
                          ? cfg_data_bits : 4'(DATA_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_line) w_next_state = S_START;
            S_START:  if (w_bit_end) w_next_state = r_start_hi ? S_IDLE : S_DATA;
            S_DATA:   if (w_bit_end && w_last_data) w_next_state = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_next_state = S_STOP;
            // Leave at the last stop-bit sample so a following start edge is not missed.
            S_STOP:   if (w_commit) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        rx_busy   = (r_state != S_IDLE);
        dbg_state = r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= 4'd0;
            r_stop_idx <= 1'b0;
            r_bits     <= 4'(DATA_W);
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_stop2    <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_start_hi <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if (baud_tick) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_line) begin
                        r_bits     <= w_cfg_bits;
                        r_par_en   <= cfg_parity_en;
                        r_par_odd  <= cfg_parity_odd;
                        r_stop2    <= cfg_stop2;
                        r_shift    <= '0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_start_hi <= 1'b0;
                        r_bit_idx  <= 4'd0;
                        r_stop_idx <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_sample_pt) r_start_hi <= w_sample_bit;
                end
                S_DATA: begin
                    if (w_sample_pt) begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (r_bit_idx == 4'(i)) r_shift[i] <= w_sample_bit;
                        end
                    end
                    if (w_bit_end) r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
                end
                S_PARITY: begin
                    if (w_sample_pt) r_perr <= (^r_shift) ^ w_sample_bit ^ r_par_odd;
                end
                S_STOP: begin
                    if (w_sample_pt && !w_sample_bit) r_ferr <= 1'b1;
                    if (w_bit_end) r_stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A commit on a transfer cycle reloads the buffer; a commit into a full, stalled buffer is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_out_data <= '0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_commit) begin
                if (!r_valid || rx_out_ready) begin
                    r_valid    <= 1'b1;
                    r_out_data <= r_shift;
                    r_out_perr <= r_perr;
                    r_out_ferr <= w_ferr_final;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_out_valid = r_valid;
    assign rx_out_data  = r_out_data;
    assign rx_out_perr  = r_out_perr;
    assign rx_out_ferr  = r_out_ferr;
    assign rx_overrun   = r_overrun;

endmodule
